// File: rtl/dds_cmd_ctrl_if.sv
// Byte/register bus bundle for dds_cmd_ctrl.
//   master : the command controller (consumes UART rx/tx status, drives tx and register bus)
//   slave  : the environment (UART rx/tx and the DDS register file)
// Signals:
//   rx_data/rx_valid     received byte and its one-cycle strobe
//   tx_busy              transmitter shifting a byte
//   tx_start/tx_data     one-cycle send request and the response byte
//   reg_wr_en            one-cycle DDS register write strobe
//   reg_addr/reg_wdata   register address/data, held between writes
interface dds_cmd_ctrl_if;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        tx_busy;
  logic        tx_start;
  logic [7:0]  tx_data;
  logic        reg_wr_en;
  logic [7:0]  reg_addr;
  logic [31:0] reg_wdata;

  modport master (
    input  rx_data, rx_valid, tx_busy,
    output tx_start, tx_data, reg_wr_en, reg_addr, reg_wdata
  );

  modport slave (
    output rx_data, rx_valid, tx_busy,
    input  tx_start, tx_data, reg_wr_en, reg_addr, reg_wdata
  );
endinterface

// File: rtl/dds_cmd_ctrl.sv
// Command sequencer between the UART and the DDS register bank.
// Parses 7-byte frames (0x55, ADDR, D3..D0, CHK=XOR of ADDR..D0), issues one
// register write per valid frame and answers every completed frame with one
// ACK/NAK byte. Mid-frame silence aborts the frame without a response.
// Ports:
//   sys_clk, sys_rst_n  clock and asynchronous active-low reset
//   bus (master)        UART rx/tx handshake and DDS register bus
//   busy                high whenever the sequencer is not idle
//   err_cnt             saturating count of checksum failures, timeouts and dropped bytes
module dds_cmd_ctrl #(
  parameter int unsigned TIMEOUT_CYC = 20000,
  parameter logic [7:0]  ACK_BYTE    = 8'hA5,
  parameter logic [7:0]  NAK_BYTE    = 8'hEE
) (
  input  logic              sys_clk,
  input  logic              sys_rst_n,
  dds_cmd_ctrl_if.master    bus,
  output logic              busy,
  output logic [7:0]        err_cnt
);

  localparam int unsigned TMO_W    = 16;
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYC - 1);
  localparam logic [7:0] HDR_BYTE  = 8'h55;

  typedef enum logic [2:0] {
    S_IDLE, S_ADDR, S_DATA, S_CHK, S_WRITE, S_RESP
  } state_t;

  state_t           state;
  logic [7:0]       addr_sh;
  logic [31:0]      data_sh;
  logic [7:0]       xor_acc;
  logic [1:0]       byte_cnt;
  logic [TMO_W-1:0] tmo_cnt;

  logic in_frame_c;
  logic timeout_c;
  logic chk_ok_c;
  logic drop_c;
  logic err_inc_c;

  // Error sources; at most one increment per cycle regardless of how many fire.
  assign in_frame_c = (state == S_ADDR) || (state == S_DATA) || (state == S_CHK);
  assign timeout_c  = in_frame_c && !bus.rx_valid && (tmo_cnt == TMO_LAST);
  assign chk_ok_c   = (bus.rx_data == xor_acc);
  assign drop_c     = bus.rx_valid && ((state == S_WRITE) || (state == S_RESP));
  assign err_inc_c  = timeout_c || drop_c ||
                      ((state == S_CHK) && bus.rx_valid && !chk_ok_c);

  // Frame sequencer with registered outputs.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state         <= S_IDLE;
      addr_sh       <= '0;
      data_sh       <= '0;
      xor_acc       <= '0;
      byte_cnt      <= '0;
      tmo_cnt       <= '0;
      busy          <= 1'b0;
      err_cnt       <= '0;
      bus.tx_start  <= 1'b0;
      bus.tx_data   <= '0;
      bus.reg_wr_en <= 1'b0;
      bus.reg_addr  <= '0;
      bus.reg_wdata <= '0;
    end else begin
      bus.tx_start  <= 1'b0;
      bus.reg_wr_en <= 1'b0;

      if (err_inc_c && (err_cnt != 8'hFF)) begin
        err_cnt <= err_cnt + 8'd1;
      end

      if (in_frame_c) begin
        tmo_cnt <= bus.rx_valid ? '0 : tmo_cnt + TMO_W'(1);
      end

      case (state)
        S_IDLE: begin
          if (bus.rx_valid && (bus.rx_data == HDR_BYTE)) begin
            state   <= S_ADDR;
            busy    <= 1'b1;
            tmo_cnt <= '0;
          end
        end

        S_ADDR: begin
          if (timeout_c) begin
            state <= S_IDLE;
            busy  <= 1'b0;
          end else if (bus.rx_valid) begin
            addr_sh  <= bus.rx_data;
            xor_acc  <= bus.rx_data;
            byte_cnt <= '0;
            state    <= S_DATA;
          end
        end

        S_DATA: begin
          if (timeout_c) begin
            state <= S_IDLE;
            busy  <= 1'b0;
          end else if (bus.rx_valid) begin
            data_sh  <= {data_sh[23:0], bus.rx_data};
            xor_acc  <= xor_acc ^ bus.rx_data;
            byte_cnt <= byte_cnt + 2'd1;
            if (byte_cnt == 2'd3) begin
              state <= S_CHK;
            end
          end
        end

        // Write strobe is raised on the transition so it coincides with WRITE.
        S_CHK: begin
          if (timeout_c) begin
            state <= S_IDLE;
            busy  <= 1'b0;
          end else if (bus.rx_valid) begin
            if (chk_ok_c) begin
              bus.reg_wr_en <= 1'b1;
              bus.reg_addr  <= addr_sh;
              bus.reg_wdata <= data_sh;
              state         <= S_WRITE;
            end else begin
              bus.tx_data  <= NAK_BYTE;
              bus.tx_start <= !bus.tx_busy;
              state        <= S_RESP;
            end
          end
        end

        S_WRITE: begin
          bus.tx_data  <= ACK_BYTE;
          bus.tx_start <= !bus.tx_busy;
          state        <= S_RESP;
        end

        // tx_start may already be up from the previous cycle; then we are done.
        S_RESP: begin
          if (bus.tx_start) begin
            state <= S_IDLE;
            busy  <= 1'b0;
          end else if (!bus.tx_busy) begin
            bus.tx_start <= 1'b1;
          end
        end

        default: begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dds_cmd_ctrl.sv
// Self-checking bench for dds_cmd_ctrl: stimulus pushes expected writes and
// response bytes (with their expected cycle) into queues; a monitor pops and
// compares whenever the DUT strobes reg_wr_en or tx_start.
module tb_dds_cmd_ctrl;
  localparam int unsigned TMO = 20000;
  localparam logic [7:0]  ACK = 8'hA5;
  localparam logic [7:0]  NAK = 8'hEE;

  typedef struct {
    logic [7:0]  addr;
    logic [31:0] data;
    int unsigned cyc;
  } wr_t;

  typedef struct {
    logic [7:0]  b;
    int unsigned cyc;
  } tx_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        busy;
  logic [7:0]  err_cnt;
  int unsigned cyc = 0;
  int          checks = 0;
  int          errors = 0;
  int          model_err = 0;
  wr_t         exp_wr[$];
  tx_t         exp_tx[$];
  wr_t         mon_w;
  tx_t         mon_t;

  dds_cmd_ctrl_if bus();

  dds_cmd_ctrl #(
    .TIMEOUT_CYC (TMO),
    .ACK_BYTE    (ACK),
    .NAK_BYTE    (NAK)
  ) dut (
    .sys_clk   (clk),
    .sys_rst_n (rst_n),
    .bus       (bus),
    .busy      (busy),
    .err_cnt   (err_cnt)
  );

  always #10 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic int sat_inc(input int v);
    return (v < 255) ? v + 1 : 255;
  endfunction

  // Monitor: every strobe must match the oldest expectation, including its cycle.
  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.reg_wr_en) begin
        if (exp_wr.size() == 0) begin
          checks++; errors++;
          $display("FAIL wr_unexpected: got write addr %0h data %0h, expected none (cycle %0d)",
                   bus.reg_addr, bus.reg_wdata, cyc);
        end else begin
          mon_w = exp_wr.pop_front();
          chk("wr_addr", 32'(bus.reg_addr), 32'(mon_w.addr));
          chk("wr_data", bus.reg_wdata, mon_w.data);
          chk("wr_cycle", cyc, mon_w.cyc);
        end
      end
      if (bus.tx_start) begin
        if (exp_tx.size() == 0) begin
          checks++; errors++;
          $display("FAIL tx_unexpected: got tx_start byte %0h, expected none (cycle %0d)",
                   bus.tx_data, cyc);
        end else begin
          mon_t = exp_tx.pop_front();
          chk("tx_data", 32'(bus.tx_data), 32'(mon_t.b));
          chk("tx_cycle", cyc, mon_t.cyc);
        end
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Presents a byte for one cycle; s is the cycle in which its result appears.
  task automatic send_byte(input logic [7:0] b, output int unsigned s);
    bus.rx_data  = b;
    bus.rx_valid = 1'b1;
    @(posedge clk);
    #1;
    bus.rx_valid = 1'b0;
    s = cyc;
  endtask

  // Sends a full frame and records what the reference model predicts.
  task automatic send_frame(input logic [7:0] addr, input logic [31:0] data,
                            input logic [7:0] chk_b, input bit push_tx,
                            output int unsigned s);
    logic [7:0] fr [7];
    logic [7:0] x;
    fr[0] = 8'h55;
    fr[1] = addr;
    fr[2] = data[31:24];
    fr[3] = data[23:16];
    fr[4] = data[15:8];
    fr[5] = data[7:0];
    fr[6] = chk_b;
    x = 8'h00;
    for (int i = 1; i < 6; i++) x = x ^ fr[i];
    for (int i = 0; i < 7; i++) begin
      idle(int'($urandom_range(0, 2)));
      send_byte(fr[i], s);
    end
    if (chk_b == x) begin
      exp_wr.push_back('{addr: addr, data: data, cyc: s});
      if (push_tx) exp_tx.push_back('{b: ACK, cyc: s + 1});
    end else begin
      model_err = sat_inc(model_err);
      if (push_tx) exp_tx.push_back('{b: NAK, cyc: s});
    end
  endtask

  function automatic logic [7:0] xsum(input logic [7:0] a, input logic [31:0] d);
    return a ^ d[31:24] ^ d[23:16] ^ d[15:8] ^ d[7:0];
  endfunction

  initial begin
    #(20 * 200000);
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned s;
    int unsigned f;
    logic [7:0]  a;
    logic [31:0] d;
    logic [7:0]  cb;
    logic [7:0]  junk;

    bus.rx_data  = 8'h00;
    bus.rx_valid = 1'b0;
    bus.tx_busy  = 1'b0;
    rst_n        = 1'b0;
    idle(3);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_err_cnt", 32'(err_cnt), 32'd0);
    chk("rst_tx_start", 32'(bus.tx_start), 32'd0);
    chk("rst_reg_wr_en", 32'(bus.reg_wr_en), 32'd0);
    chk("rst_tx_data", 32'(bus.tx_data), 32'd0);
    chk("rst_reg_addr", 32'(bus.reg_addr), 32'd0);
    chk("rst_reg_wdata", bus.reg_wdata, 32'd0);
    rst_n = 1'b1;
    idle(2);

    // Directed good frame and its bad-checksum twin.
    send_frame(8'h10, 32'h12345678, xsum(8'h10, 32'h12345678), 1'b1, s);
    idle(3);
    chk("good_err_cnt", 32'(err_cnt), 32'(model_err));
    chk("good_busy", 32'(busy), 32'd0);
    send_frame(8'h10, 32'h12345678, 8'h00, 1'b1, s);
    idle(3);
    chk("nak_err_cnt", 32'(err_cnt), 32'd1);

    // Abandoned frame times out silently.
    send_byte(8'h55, s);
    send_byte(8'h10, s);
    send_byte(8'h12, s);
    chk("tmo_busy_mid", 32'(busy), 32'd1);
    idle(int'(TMO) + 2);
    model_err = sat_inc(model_err);
    chk("tmo_busy", 32'(busy), 32'd0);
    chk("tmo_err_cnt", 32'(err_cnt), 32'(model_err));
    send_frame(8'h21, 32'hCAFE0055, xsum(8'h21, 32'hCAFE0055), 1'b1, s);
    idle(3);
    chk("post_tmo_err_cnt", 32'(err_cnt), 32'(model_err));

    // Response held off by a busy transmitter.
    bus.tx_busy = 1'b1;
    send_frame(8'h33, 32'hDEADBEEF, xsum(8'h33, 32'hDEADBEEF), 1'b0, s);
    idle(1000);
    chk("txbusy_busy", 32'(busy), 32'd1);
    f = cyc;
    bus.tx_busy = 1'b0;
    exp_tx.push_back('{b: ACK, cyc: f + 1});
    idle(5);
    chk("txbusy_done", 32'(busy), 32'd0);

    // Reset in the middle of a frame.
    send_byte(8'h55, s);
    send_byte(8'h10, s);
    send_byte(8'h12, s);
    send_byte(8'h34, s);
    send_byte(8'h56, s);
    rst_n = 1'b0;
    #1;
    model_err = 0;
    chk("arst_busy", 32'(busy), 32'd0);
    chk("arst_err_cnt", 32'(err_cnt), 32'd0);
    chk("arst_reg_addr", 32'(bus.reg_addr), 32'd0);
    chk("arst_reg_wdata", bus.reg_wdata, 32'd0);
    chk("arst_tx_data", 32'(bus.tx_data), 32'd0);
    chk("arst_tx_start", 32'(bus.tx_start), 32'd0);
    chk("arst_reg_wr_en", 32'(bus.reg_wr_en), 32'd0);
    idle(2);
    rst_n = 1'b1;
    idle(2);
    send_byte(8'h12, s);
    send_byte(8'h34, s);
    idle(2);
    chk("garbage_busy", 32'(busy), 32'd0);
    send_frame(8'h02, 32'h00000001, 8'h03, 1'b1, s);
    idle(3);
    chk("post_rst_err_cnt", 32'(err_cnt), 32'(model_err));

    // Randomized frames with in-frame 0x55, idle garbage and dropped bytes.
    for (int n = 0; n < 80; n++) begin
      a = 8'($urandom);
      d = $urandom;
      if ($urandom_range(0, 3) == 0) d[15:8] = 8'h55;
      cb = xsum(a, d);
      if ($urandom_range(0, 3) == 0) cb = cb ^ 8'($urandom_range(1, 255));
      if ($urandom_range(0, 3) == 0) begin
        junk = 8'($urandom);
        if (junk == 8'h55) junk = 8'h54;
        send_byte(junk, s);
        idle(1);
      end
      send_frame(a, d, cb, 1'b1, s);
      if ($urandom_range(0, 3) == 0) begin
        junk = 8'($urandom);
        if (junk == 8'h55) junk = 8'h54;
        send_byte(junk, s);
        model_err = sat_inc(model_err);
      end
      idle(3);
      chk("rand_err_cnt", 32'(err_cnt), 32'(model_err));
      chk("rand_busy", 32'(busy), 32'd0);
    end

    // Bad checksums until the counter saturates.
    for (int n = 0; n < 300; n++) begin
      a = 8'($urandom);
      d = $urandom;
      send_frame(a, d, xsum(a, d) ^ 8'h80, 1'b1, s);
      idle(2);
      if (n % 50 == 49) chk("sat_err_cnt_progress", 32'(err_cnt), 32'(model_err));
    end
    idle(3);
    chk("sat_err_cnt", 32'(err_cnt), 32'd255);

    chk("wr_queue_drained", 32'(exp_wr.size()), 32'd0);
    chk("tx_queue_drained", 32'(exp_tx.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
